// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: word size, default NOP encoding,
// the (pc, instr) entry carried by output and skid registers, and the
// request FSM state type.
package fetch_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE_REQ  = 2'd0,  // nothing in flight
    WAIT_RESP = 2'd1,  // one request in flight, response will be kept
    WAIT_DROP = 2'd2   // one request in flight, response will be discarded
  } fetch_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel.
//   imem_req/imem_addr   : request valid and word address (fetch side drives)
//   imem_ready           : request accepted when imem_req && imem_ready
//   imem_rvalid/rdata    : one in-order response per accepted request
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_unit_skid.sv
// One-entry holding register for a response that arrives while the output
// slot is stalled.
//   clock, reset : clock and async active-low reset
//   load/din     : capture din (ignored while flush)
//   unload       : release the held entry
//   flush        : discard the held entry (highest priority)
//   valid/dout   : held entry
module fetch_unit_skid
  import fetch_unit_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         unload,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         valid,
  output fetch_entry_t dout
);

  logic         valid_q, valid_d;
  fetch_entry_t entry_q, entry_d;

  // Next-entry selection: flush > load > unload.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      entry_d = din;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign valid = valid_q;
  assign dout  = entry_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word read at a
// time, and presents (pc, instr) to the IF/ID register with stall, redirect
// flush and a one-entry skid buffer.
//   clock, reset       : clock and async active-low reset
//   stall              : downstream IF/ID register holds
//   redirect/_pc       : flush and restart fetch at redirect_pc
//   imem               : instruction-memory read channel (master side)
//   valid_out/pc_out/instr_out : presented instruction (0/NOP when invalid)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic                valid_out,
  output logic [31:0]         pc_out,
  output logic [31:0]         instr_out
);

  localparam fetch_entry_t BUBBLE = '{pc: '0, instr: NOP_INSTR};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  fetch_entry_t    out_q, out_d;
  logic            valid_q, valid_d;

  logic            outstanding;
  logic            rsp_fire;
  logic            rsp_keep;
  logic            req_c;
  logic            accept;
  fetch_entry_t    rsp_entry;

  logic            skid_valid;
  fetch_entry_t    skid_entry;
  logic            skid_load, skid_unload, skid_flush;

  assign outstanding = (state_q != IDLE_REQ);
  assign rsp_fire    = imem.imem_rvalid && outstanding;
  assign rsp_keep    = rsp_fire && (state_q == WAIT_RESP) && !redirect;
  assign rsp_entry   = '{pc: req_pc_q, instr: imem.imem_rdata};

  // Request is combinational so a returning response can be overlapped with
  // the next request; reset gates it so nothing is requested while held.
  assign req_c  = reset && !redirect && !stall && !skid_valid &&
                  (!outstanding || rsp_fire);
  assign accept = req_c && imem.imem_ready;

  // Next state for PC, request FSM, output slot and skid control.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    out_d       = out_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_flush  = 1'b0;

    if (redirect) begin
      // Flush wins over stall; an in-flight request not answered this cycle
      // must have its response swallowed later.
      fetch_pc_d = redirect_pc;
      out_d      = BUBBLE;
      valid_d    = 1'b0;
      skid_flush = 1'b1;
      state_d    = (outstanding && !imem.imem_rvalid) ? WAIT_DROP : IDLE_REQ;
    end else begin
      if (accept) begin
        fetch_pc_d = next_pc(fetch_pc_q);
        req_pc_d   = fetch_pc_q;
        state_d    = WAIT_RESP;
      end else if (rsp_fire) begin
        state_d    = IDLE_REQ;
      end

      if (!stall) begin
        if (skid_valid) begin
          // Requests are blocked while the skid is full, so no response can
          // collide with the unload.
          out_d       = skid_entry;
          valid_d     = 1'b1;
          skid_unload = 1'b1;
        end else if (rsp_keep) begin
          out_d   = rsp_entry;
          valid_d = 1'b1;
        end else begin
          out_d   = BUBBLE;
          valid_d = 1'b0;
        end
      end else if (rsp_keep) begin
        if (!valid_q) begin
          out_d   = rsp_entry;
          valid_d = 1'b1;
        end else begin
          skid_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      out_q      <= BUBBLE;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
    end
  end

  fetch_unit_skid u_skid (
    .clock  (clock),
    .reset  (reset),
    .load   (skid_load),
    .unload (skid_unload),
    .flush  (skid_flush),
    .din    (rsp_entry),
    .valid  (skid_valid),
    .dout   (skid_entry)
  );

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = fetch_pc_q;

  assign valid_out = valid_q;
  assign pc_out    = out_q.pc;
  assign instr_out = out_q.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory returning addr+0x100, a
// scoreboard of accepted requests compared as the downstream stage consumes
// them, and directed checks for reset, stall, redirect and back-pressure.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid_out;
  logic [31:0] pc_out, instr_out;

  int checks = 0;
  int errors = 0;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clock       (clk),
    .reset       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem.master),
    .valid_out   (valid_out),
    .pc_out      (pc_out),
    .instr_out   (instr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: one pending request, fixed latency, data = addr + 0x100.
  int          lat = 1;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pend <= 1'b0;
      mem_addr <= 32'h0;
      mem_cnt  <= 0;
    end else if (imem.imem_req && imem.imem_ready) begin
      mem_pend <= 1'b1;
      mem_addr <= imem.imem_addr;
      mem_cnt  <= lat - 1;
    end else if (mem_pend && mem_cnt == 0) begin
      mem_pend <= 1'b0;
    end else if (mem_pend) begin
      mem_cnt  <= mem_cnt - 1;
    end
  end

  assign imem.imem_rvalid = mem_pend && (mem_cnt == 0);
  assign imem.imem_rdata  = mem_addr + 32'h100;

  // Scoreboard: push on accept, pop when downstream consumes, clear on flush.
  fetch_entry_t sb[$];
  fetch_entry_t exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (!valid_out) begin
        chk("bubble_pc", pc_out, 32'h0);
        chk("bubble_instr", instr_out, NOP);
      end
      if (valid_out && !stall && !redirect) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_e = sb.pop_front();
          chk("sb_pc", pc_out, exp_e.pc);
          chk("sb_instr", instr_out, exp_e.instr);
        end
      end
      if (redirect) sb.delete();
      if (imem.imem_req && imem.imem_ready)
        sb.push_back('{pc: imem.imem_addr, instr: imem.imem_addr + 32'h100});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the first presented instruction and check its pc.
  task automatic expect_first_valid(input string tag, input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (valid_out) found = 1'b1;
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_pc"}, pc_out, pc);
      chk({tag, "_instr"}, instr_out, pc + 32'h100);
    end
  endtask

  initial begin
    bit found;
    imem.imem_ready = 1'b1;

    // Reset values
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    tick();
    rst_n = 1'b1;

    // Zero-wait stream: addresses 0,4,8 back to back, first valid after 2 cycles
    @(negedge clk);
    chk("c0_req", 32'(imem.imem_req), 32'd1);
    chk("c0_addr", imem.imem_addr, 32'h0);
    @(negedge clk);
    chk("c1_addr", imem.imem_addr, 32'h4);
    chk("c1_valid", 32'(valid_out), 32'd0);
    @(negedge clk);
    chk("c2_addr", imem.imem_addr, 32'h8);
    chk("c2_valid", 32'(valid_out), 32'd1);
    chk("c2_pc", pc_out, 32'h0);
    chk("c2_instr", instr_out, 32'h100);

    // Stall 3 cycles while response for pc=8 is in flight
    tick();
    stall = 1'b1;
    @(negedge clk);
    chk("st0_pc", pc_out, 32'h4);
    chk("st0_instr", instr_out, 32'h104);
    chk("st0_req", 32'(imem.imem_req), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("st_hold_pc", pc_out, 32'h4);
      chk("st_hold_req", 32'(imem.imem_req), 32'd0);
    end
    tick();
    stall = 1'b0;
    lat = 3;
    @(negedge clk);
    chk("rel0_pc", pc_out, 32'h4);
    @(negedge clk);
    chk("rel1_valid", 32'(valid_out), 32'd1);
    chk("rel1_pc", pc_out, 32'h8);

    // Latency 3: redirect to 0x40 one cycle after accept of 0x10
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (imem.imem_req && imem.imem_ready && imem.imem_addr == 32'h10) found = 1'b1;
    end
    chk("acc10_seen", 32'(found), 32'd1);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    chk("rd_req", 32'(imem.imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("rd_bubble", 32'(valid_out), 32'd0);
    chk("rd_wait_req", 32'(imem.imem_req), 32'd0);
    expect_first_valid("rd_first", 32'h40);

    // Redirect while stalled with the skid full
    lat = 1;
    for (int i = 0; i < 6; i++) tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (imem.imem_req && imem.imem_ready && valid_out) found = 1'b1;
    end
    chk("rs_stream", 32'(found), 32'd1);
    tick();
    stall = 1'b1;
    @(negedge clk);
    chk("rs_stall_valid", 32'(valid_out), 32'd1);
    chk("rs_stall_req", 32'(imem.imem_req), 32'd0);
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("rs_rd_req", 32'(imem.imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("rs_valid", 32'(valid_out), 32'd0);
    chk("rs_instr", instr_out, NOP);
    chk("rs_pc", pc_out, 32'h0);
    tick();
    @(negedge clk);
    chk("rs_hold_req", 32'(imem.imem_req), 32'd0);
    chk("rs_hold_valid", 32'(valid_out), 32'd0);
    tick();
    stall = 1'b0;
    @(negedge clk);
    chk("rs_restart_addr", imem.imem_addr, 32'h200);
    expect_first_valid("rs_first", 32'h200);

    // Async reset mid-cycle with a request outstanding
    for (int i = 0; i < 3; i++) tick();
    #2;
    chk("ar_pre_valid", 32'(valid_out), 32'd1);
    rst_n = 1'b0;
    imem.imem_ready = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_out), 32'd0);
    chk("ar_pc", pc_out, 32'h0);
    chk("ar_instr", instr_out, NOP);
    chk("ar_req", 32'(imem.imem_req), 32'd0);
    tick();
    rst_n = 1'b1;

    // imem_ready low for 5 cycles after reset: request held, no output
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nr_req", 32'(imem.imem_req), 32'd1);
      chk("nr_addr", imem.imem_addr, 32'h0);
      chk("nr_valid", 32'(valid_out), 32'd0);
      chk("nr_pc", pc_out, 32'h0);
    end
    tick();
    imem.imem_ready = 1'b1;
    expect_first_valid("nr_first", 32'h0);

    for (int i = 0; i < 10; i++) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the program counter and issues word reads to instruction memory.
- Presents (pc, instr) to the IF/ID pipeline register directly downstream.
- Honours the same active-high stall that freezes that register, plus branch/jump redirects from later stages.
- Supports variable-latency memory: one outstanding request, one-entry skid buffer, NOP bubbles on empty or flushed cycles.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0000, value driven on instr_out when no valid instruction (sll $0,$0,0)

Ports:
- clock  in  1  single clock; all flops rising-edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  1 = downstream IF/ID register holds; same signal drives that register's hold input
- redirect  in  1  1 = discard everything fetched, restart at redirect_pc
- redirect_pc  in  32  new fetch address, word aligned
- imem_req  out  1  read request valid
- imem_addr  out  32  read address, meaningful when imem_req=1
- imem_ready  in  1  request accepted this cycle (imem_req && imem_ready)
- imem_rvalid  in  1  read data valid; exactly one per accepted request, in order, ≥1 cycle after accept
- imem_rdata  in  32  instruction word
- valid_out  out  1  pc_out/instr_out hold a real instruction
- pc_out  out  32  address of presented instruction (0 when invalid)
- instr_out  out  32  presented instruction (NOP_INSTR when invalid)

Behaviour:
- Reset (reset=0, async):
  - fetch_pc=RESET_PC, outstanding=0, drop=0, skid empty.
  - valid_out=0, pc_out=0, instr_out=NOP_INSTR, imem_req=0.
  - First imem_req is driven in the first cycle after reset deasserts.
  - Reset mid-transaction abandons the in-flight request. The memory is reset by the same signal.
- Request issue:
  - imem_req = !redirect && !stall && !skid_valid && (outstanding==0 || imem_rvalid).
  - imem_addr=fetch_pc.
  - On accept: outstanding=1 and fetch_pc += 4 (wraps mod 2^32). Otherwise fetch_pc holds.
  - A dropped unaccepted request may change address next cycle; the memory permits withdrawal.
- Response routing, on imem_rvalid with drop=0, paired with the PC captured at accept:
  - Output slot free (!stall or !valid_out): load output regs, valid_out=1.
  - Else: write skid buffer.
  - outstanding clears unless a new accept occurs in the same cycle.
- Output advance, when stall=0 each cycle:
  - Skid valid: skid→output, skid cleared.
  - Else response arriving: response→output.
  - Else: valid_out=0, pc_out=0, instr_out=NOP_INSTR (bubble).
- Stall=1: output regs and skid hold. No new request. The in-flight response (at most one) goes to skid.
- Redirect (highest priority, 1-cycle pulse):
  - Next edge: fetch_pc=redirect_pc, valid_out=0, NOP on outputs, skid cleared.
  - If outstanding=1 and no rvalid this cycle, drop=1.
  - The next rvalid with drop=1 is discarded, clearing drop and outstanding.
  - imem_req is 0 during the redirect cycle. Requests resume the following cycle, gated by the normal rule (outstanding must clear).
  - Redirect overrides stall for flushing: outputs become a bubble even if stall=1.
- Throughput: with a zero-wait, 1-cycle-latency memory, one instruction per cycle. Latency from first request to valid_out is 2 cycles.
- Invariants (for verification):
  - Outstanding ≤1; skid ≤1.
  - No rvalid lost or duplicated.
  - pc_out sequence strictly +4 between redirects.

Decomposition:
- Shared package (pipeline_pkg):
  - NOP_INSTR constant.
  - Word-size constant 4.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}, used for both output and skid registers.
- One natural sub-module: fetch_skid, a one-entry holding register with valid bit, load/unload/flush.
- The PC and request FSM (states IDLE_REQ, WAIT_RESP, WAIT_DROP) stay in fetch_unit.

Test Plan:
- Reset, zero-wait memory returning addr+0x100:
  - imem_addr 0,4,8 on consecutive cycles.
  - valid_out=1, pc_out=0, instr_out=0x100 two cycles after reset release, then 4/0x104 next cycle.
- Stall for 3 cycles while response for pc=8 is in flight:
  - Output holds pc=4; pc=8 goes to skid; imem_req=0.
  - On release: pc=8 then pc=0xC, no gap or duplicate.
- Memory latency 3, redirect to 0x40 one cycle after accept of 0x10:
  - Response for 0x10 discarded.
  - Next valid pc_out=0x40; no instruction from 0x10 ever valid.
- Redirect with stall=1 and skid full:
  - Next cycle valid_out=0, instr_out=NOP_INSTR, skid empty.
  - Fetch restarts at redirect_pc after stall drops.
- Async reset asserted mid-cycle while outstanding=1:
  - Outputs go to 0/NOP immediately without a clock edge.
  - After release, first imem_addr=RESET_PC.
- imem_ready held low 5 cycles:
  - imem_req and imem_addr stay stable, fetch_pc does not advance.
  - valid_out=0 and pc_out=0 throughout.
